// File: rtl/render_cmd_sequencer.sv
// render_cmd_sequencer: queues CPU draw commands and replays each into the renderer's Avalon slave.
// Ports: clk/rst_n (async active-low); slave_* CPU-facing Avalon slave (addr0 push, addr1 status/clear,
// addr2 mode, addr3 frame_cnt); rnd_* Avalon master toward the renderer register interface.
// Optional SEQ_WATCHDOG_EN builds a stall watchdog (WDOG_CYCLES) that aborts a stuck command.
module render_cmd_sequencer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 5,
  parameter int WDOG_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [3:0]  rnd_address,
  output logic        rnd_read,
  input  logic [31:0] rnd_readdata,
  output logic        rnd_write,
  output logic [31:0] rnd_writedata,
  input  logic        rnd_waitrequest
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [3:0] {S_IDLE, S_MODE, S_COOR, S_TEX, S_START, S_PAR, S_PCAP, S_POLL, S_PDATA} state_t;
  state_t state, state_n;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0] cmd_r, frame_cnt, status;
  logic overflow, wdog_err, mode, mode_pending, par0;
  logic empty, full, push, push_ok, pop, clr, mode_wr, abort, busy;
  logic unused_rd;
  assign unused_rd = ^rnd_readdata[31:1];
  assign empty = count == '0;
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign push = slave_write && slave_address == 3'd0;
  assign push_ok = push && !full;
  assign clr = slave_write && slave_address == 3'd1;
  assign mode_wr = slave_write && slave_address == 3'd2;
  assign busy = state != S_IDLE;
  assign slave_waitrequest = 1'b0;
  assign status = {22'b0, wdog_err, overflow, busy, full, empty, 5'(count)};
  // Strobes are decoded from the state register, so they hold steady while stalled
  // and fall as soon as the state advances past an accepted transfer.
  always_comb begin
    state_n = state;
    pop = 1'b0;
    rnd_address = '0;
    rnd_read = 1'b0;
    rnd_write = 1'b0;
    rnd_writedata = '0;
    case (state)
      S_IDLE: begin
        pop = !mode_pending && !empty;
        state_n = mode_pending ? S_MODE : !empty ? S_COOR : S_IDLE;
      end
      S_MODE: begin
        rnd_write = 1'b1;
        rnd_writedata = cmd_r;
        state_n = rnd_waitrequest ? S_MODE : S_IDLE;
      end
      S_COOR: begin
        rnd_write = 1'b1;
        rnd_address = 4'd1;
        rnd_writedata = {14'b0, cmd_r[24:7]};
        state_n = rnd_waitrequest ? S_COOR : S_TEX;
      end
      S_TEX: begin
        rnd_write = 1'b1;
        rnd_address = 4'd2;
        rnd_writedata = {25'b0, cmd_r[6:0]};
        state_n = rnd_waitrequest ? S_TEX : S_START;
      end
      S_START: begin
        rnd_write = 1'b1;
        rnd_address = 4'd4;
        state_n = rnd_waitrequest ? S_START : S_PAR;
      end
      S_PAR: begin
        rnd_read = 1'b1;
        rnd_address = 4'd3;
        state_n = rnd_waitrequest ? S_PAR : S_PCAP;
      end
      S_PCAP: state_n = cmd_r[31] ? S_POLL : S_IDLE;
      S_POLL: begin
        rnd_read = 1'b1;
        rnd_address = 4'd3;
        state_n = rnd_waitrequest ? S_POLL : S_PDATA;
      end
      S_PDATA: state_n = rnd_readdata[0] != par0 ? S_IDLE : S_POLL;
      default: state_n = S_IDLE;
    endcase
  end
`ifdef SEQ_WATCHDOG_EN
  logic [31:0] wdog_cnt;
  assign abort = busy && state_n == state && wdog_cnt == 32'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog_cnt <= '0;
    else wdog_cnt <= (!busy || state_n != state || abort) ? '0 : wdog_cnt + 32'd1;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= slave_writedata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cmd_r <= '0;
      frame_cnt <= '0;
      overflow <= 1'b0;
      wdog_err <= 1'b0;
      mode <= 1'b0;
      mode_pending <= 1'b0;
      par0 <= 1'b0;
      slave_readdata <= '0;
    end else begin
      state <= abort ? S_IDLE : state_n;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      overflow <= (push && full) ? 1'b1 : clr ? 1'b0 : overflow;
      wdog_err <= abort ? 1'b1 : clr ? 1'b0 : wdog_err;
      if (mode_wr) mode <= slave_writedata[0];
      mode_pending <= mode_wr ? 1'b1 : (state == S_MODE && !rnd_waitrequest) ? 1'b0 : mode_pending;
      // The mode word is snapshotted into cmd_r so its data stays stable if the CPU rewrites mode mid-stall.
      cmd_r <= pop ? mem[rd_ptr] : (state == S_IDLE && mode_pending) ? {31'b0, mode} : abort ? '0 : cmd_r;
      if (state == S_PCAP) par0 <= rnd_readdata[0];
      if (state == S_PDATA && rnd_readdata[0] != par0) frame_cnt <= frame_cnt + 32'd1;
      slave_readdata <= !slave_read ? '0 : slave_address == 3'd1 ? status : slave_address == 3'd3 ? frame_cnt : '0;
    end
endmodule

// File: tb/tb_render_cmd_sequencer.sv
// tb_render_cmd_sequencer: directed and random checks of render_cmd_sequencer against a renderer model.
module tb_render_cmd_sequencer;
  logic clk = 0, rst_n = 0;
  logic [2:0] slave_address = 0;
  logic slave_read = 0, slave_write = 0;
  logic [31:0] slave_writedata = 0, slave_readdata;
  logic slave_waitrequest;
  logic [3:0] rnd_address;
  logic rnd_read, rnd_write, rnd_waitrequest;
  logic [31:0] rnd_readdata, rnd_writedata;
  int total = 0, bad = 0;
  int wait_cfg = 0, flip_delay = 0;
  bit hold = 0;
  int wcnt, flip_timer, rd_cnt = 0, early = 0, unstable = 0, chk_idx = 0;
  logic par, stalled_prev;
  logic [37:0] prev_sig;
  logic [35:0] wlog[$], exp_q[$];

  render_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .slave_address(slave_address), .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
    .rnd_address(rnd_address), .rnd_read(rnd_read), .rnd_readdata(rnd_readdata),
    .rnd_write(rnd_write), .rnd_writedata(rnd_writedata), .rnd_waitrequest(rnd_waitrequest)
  );

  always #5 clk = ~clk;

  // Renderer model: wait_cfg stall cycles per access (or forever when hold), parity flips
  // flip_delay cycles after a start write, accepted writes are logged as {addr, data}.
  assign rnd_waitrequest = (rnd_read || rnd_write) && (hold || wcnt < wait_cfg);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= 0;
      flip_timer <= 0;
      par <= 0;
      rnd_readdata <= 0;
      stalled_prev <= 0;
      prev_sig <= 0;
    end else begin
      if (stalled_prev && prev_sig !== {rnd_read, rnd_write, rnd_address, rnd_writedata}) unstable++;
      if (rnd_read && rnd_write) unstable++;
      stalled_prev <= rnd_waitrequest;
      prev_sig <= {rnd_read, rnd_write, rnd_address, rnd_writedata};
      if (flip_timer == 1) par <= ~par;
      if (flip_timer > 0) flip_timer <= flip_timer - 1;
      if ((rnd_read || rnd_write) && !rnd_waitrequest) begin
        wcnt <= 0;
        if (rnd_write) begin
          wlog.push_back({rnd_address, rnd_writedata});
          if (rnd_address == 4'd1 && flip_timer > 0) early++;
          if (rnd_address == 4'd4 && flip_delay > 0) flip_timer <= flip_delay;
        end else begin
          rd_cnt++;
          rnd_readdata <= {31'b0, par};
        end
      end else if (rnd_read || rnd_write) wcnt <= wcnt + 1;
    end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    slave_address = a;
    slave_writedata = d;
    slave_write = 1;
    @(negedge clk);
    slave_write = 0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    slave_address = a;
    slave_read = 1;
    @(negedge clk);
    slave_read = 0;
    d = slave_readdata;
  endtask

  task automatic add_exp(input logic [31:0] c);
    exp_q.push_back({4'd1, 14'b0, c[24:7]});
    exp_q.push_back({4'd2, 25'b0, c[6:0]});
    exp_q.push_back({4'd4, 32'b0});
  endtask

  task automatic check_log(input string tag);
    check({tag, " len"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int i = chk_idx; i < exp_q.size() && i < wlog.size(); i++) check(tag, 64'(wlog[i]), 64'(exp_q[i]));
    chk_idx = exp_q.size();
  endtask

  task automatic wait_idle(input int max, input string tag);
    logic [31:0] d;
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      cpu_read(3'd1, d);
      ok = !d[7] && d[5];
    end
    check({tag, " idle"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, c, a, b;
    int r0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check("reset rnd_write", 64'(rnd_write), 64'd0);
    check("reset rnd_read", 64'(rnd_read), 64'd0);
    check("slave_waitrequest", 64'(slave_waitrequest), 64'd0);
    cpu_read(3'd1, d);
    check("reset status", 64'(d), 64'h20);
    cpu_read(3'd3, d);
    check("reset frame_cnt", 64'(d), 64'd0);
    cpu_read(3'd5, d);
    check("other addr", 64'(d), 64'd0);

    // single fill command, no stalls; busy must be clear 6 cycles after the pop
    r0 = rd_cnt;
    cpu_write(3'd0, 32'h0000_0040);
    add_exp(32'h0000_0040);
    repeat (6) @(negedge clk);
    cpu_read(3'd1, d);
    check("t1 status", 64'(d), 64'h20);
    check("t1 reads", 64'(rd_cnt - r0), 64'd1);
    check_log("t1 log");

    // 10 wait cycles on every access
    wait_cfg = 10;
    c = {7'b0, 18'h12345, 7'h05};
    cpu_write(3'd0, c);
    add_exp(c);
    wait_idle(200, "t2");
    check_log("t2 log");
    wait_cfg = 0;

    // end-of-frame command: next command must wait for the parity flip
    flip_delay = 500;
    r0 = rd_cnt;
    a = {1'b1, 6'b0, 18'h00abc, 7'h11};
    b = {1'b0, 6'b0, 18'h3ffff, 7'h7f};
    cpu_write(3'd0, a);
    cpu_write(3'd0, b);
    add_exp(a);
    add_exp(b);
    wait_idle(1500, "t3");
    flip_delay = 0;
    cpu_read(3'd3, d);
    check("t3 frame_cnt", 64'(d), 64'd1);
    check("t3 polls", 64'(rd_cnt - r0 >= 100), 64'd1);
    check("t3 early issue", 64'(early), 64'd0);
    check_log("t3 log");

    // overflow: one command stuck in flight, 17 pushes into 16 entries
    hold = 1;
    c = 32'h0000_1000;
    cpu_write(3'd0, c);
    add_exp(c);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      c = {7'b0, 18'(i * 37 + 5), 7'(i)};
      cpu_write(3'd0, c);
      if (i < 16) add_exp(c);
    end
    cpu_read(3'd1, d);
    check("t4 status full", 64'(d), 64'((1 << 8) | (1 << 7) | (1 << 6) | 16));
    cpu_write(3'd1, 32'hdead_beef);
    cpu_read(3'd1, d);
    check("t4 status cleared", 64'(d), 64'((1 << 7) | (1 << 6) | 16));
    hold = 0;
    wait_idle(2000, "t4");
    check_log("t4 log");

    // mode write while a command is in flight lands between commands
    wait_cfg = 5;
    a = {7'b0, 18'h00001, 7'h01};
    b = {7'b0, 18'h00002, 7'h02};
    cpu_write(3'd0, a);
    cpu_write(3'd0, b);
    repeat (3) @(negedge clk);
    cpu_write(3'd2, 32'h1);
    add_exp(a);
    exp_q.push_back({4'd0, 32'd1});
    add_exp(b);
    wait_idle(500, "t5");
    check_log("t5 log");

    // random commands with random stall lengths
    for (int i = 0; i < 24; i++) begin
      wait_cfg = $urandom_range(0, 3);
      c = {7'b0, 18'($urandom), 7'($urandom)};
      cpu_write(3'd0, c);
      add_exp(c);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if (i % 8 == 7) wait_idle(1000, "rand");
    end
    wait_cfg = 0;
    check_log("rand log");
    check("bus stability", 64'(unstable), 64'd0);

    // asynchronous reset mid-transaction discards everything
    hold = 1;
    cpu_write(3'd0, 32'h0000_0101);
    cpu_write(3'd0, 32'h0000_0202);
    cpu_write(3'd0, 32'h0000_0303);
    check("pre-reset write strobe", 64'(rnd_write), 64'd1);
    #2 rst_n = 0;
    #1;
    check("rst drops write", 64'(rnd_write), 64'd0);
    check("rst drops read", 64'(rnd_read), 64'd0);
    @(negedge clk);
    rst_n = 1;
    hold = 0;
    cpu_read(3'd1, d);
    check("post-reset status", 64'(d), 64'h20);
    cpu_read(3'd3, d);
    check("post-reset frame_cnt", 64'(d), 64'd0);
    check_log("final log");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/render_cmd_sequencer.md
Name: render_cmd_sequencer

Overview:
- Queues draw commands from the CPU and replays each one into the renderer's Avalon slave register interface.
- Per command it writes coordinates (addr 1), writes tex_code (addr 2), pulses start (addr 4), then waits for the plot to finish.
- Optionally it also waits for the renderer's frame-parity flip, so the CPU can queue a whole frame and not babysit waitrequest.
- Sits on the HPS/Avalon fabric between the CPU and the renderer slave port.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries (power of 2, 2..64).
- CNT_W, 5, width of the FIFO occupancy count (log2(FIFO_DEPTH)+1).
- WDOG_CYCLES, 2000000, watchdog limit in clocks (used only when SEQ_WATCHDOG_EN is defined).

Ports:
- clk, in, 1: system clock (50 MHz).
- rst_n, in, 1: asynchronous, active-low reset.
- slave_address, in, 3: CPU register select.
- slave_read, in, 1: CPU read strobe.
- slave_readdata, out, 32: CPU read data, registered.
- slave_write, in, 1: CPU write strobe.
- slave_writedata, in, 32: CPU write data.
- slave_waitrequest, out, 1: always 0; the CPU is never stalled.
- rnd_address, out, 4: renderer register address.
- rnd_read, out, 1: renderer read strobe.
- rnd_readdata, in, 32: renderer read data, valid the cycle after a read is accepted.
- rnd_write, out, 1: renderer write strobe.
- rnd_writedata, out, 32: renderer write data.
- rnd_waitrequest, in, 1: renderer stall.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FIFO empty; overflow=0; frame_cnt=0; mode_pending=0; FSM in IDLE. Reset mid-transaction drops rnd_read/rnd_write immediately and discards the FIFO contents.
- CPU write, addr 0: push slave_writedata into the FIFO.
  - Command format: [6:0] tex_code; [24:7] coordinates; [31] eof.
  - Push while full: word is dropped and sticky overflow is set.
- CPU write, addr 1: any value clears overflow (and wdog_err).
- CPU write, addr 2: latch mode=wd[0] and set mode_pending.
- CPU read data appears the cycle after slave_read:
  - addr 1: {22'b0, wdog_err, overflow, busy, full, empty, count[CNT_W-1:0]} (count zero-extended into bits [4:0]).
  - addr 3: frame_cnt[31:0].
  - Other addresses: 0.
- Simultaneous push and pop: count is unchanged and both operations take effect. Pop happens only on the IDLE->WR_COOR transition.
- Renderer bus rules:
  - rnd_address, rnd_read and rnd_write stay stable while rnd_waitrequest=1.
  - A transfer completes on a cycle where the strobe is high and rnd_waitrequest=0.
  - Only one strobe is active at a time; the strobe drops the cycle after acceptance.
- FSM:
  - IDLE: if mode_pending -> WR_MODE. Else if FIFO not empty -> pop into cmd_r -> WR_COOR. busy=0 only in IDLE.
  - WR_MODE: write addr 0, data {31'b0, mode}. On accept, clear mode_pending -> IDLE. A CPU addr-2 write in the same cycle re-sets mode_pending with the new value.
  - WR_COOR: write addr 1, data {14'b0, cmd_r[24:7]} -> WR_TEX.
  - WR_TEX: write addr 2, data {25'b0, cmd_r[6:0]} -> START.
  - START: write addr 4, data 0 -> PARITY.
  - PARITY: read addr 3; the renderer stalls here until the plot completes. On accept -> PAR_CAP.
  - PAR_CAP: capture par0=rnd_readdata[0]. If cmd_r[31]=0 -> IDLE, else -> EOF_POLL.
  - EOF_POLL: read addr 3 repeatedly, with one idle cycle between accepted reads. On the data cycle:
    - bit0 != par0: frame_cnt++ (wraps at 2^32) -> IDLE.
    - Otherwise repeat.
- A command is never partially re-issued; once popped it runs to completion (watchdog abort excepted).

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- When defined:
  - A counter tracks consecutive cycles in any non-IDLE state without FSM progress.
  - On reaching WDOG_CYCLES: drop strobes, set sticky wdog_err, discard cmd_r, go to IDLE.
  - The FIFO is preserved.
- When undefined: no counter is built, wdog_err reads 0, and the FSM waits indefinitely.

Test Plan:
- Push 0x0000_0040 (fill color 0), renderer model never stalls -> writes (1,0x0),(2,0x40),(4,0), then read addr3; busy back to 0 within 6 cycles of pop.
- Push cmd coords=0x12345, tex=5; renderer holds waitrequest 10 cycles on each access -> address/data held stable throughout; exact sequence 1/0x12345, 2/0x05, 4.
- Push eof command, model parity flips 500 cycles after start -> EOF_POLL reads repeat; frame_cnt reads 1 at addr3; FIFO next entry issued only after flip.
- Push 17 words into a 16-deep FIFO while renderer stalled -> status count=16, full=1, overflow=1; write addr1 clears overflow; 16 commands replayed in order.
- Write addr2=1 while a command is in flight -> mode write (0,1) issued only after current command returns to IDLE and before next pop.
- SEQ_WATCHDOG_EN, WDOG_CYCLES=100, renderer stalls forever at START -> after 100 cycles strobes drop, wdog_err=1, FIFO count unchanged.
